flappy_game_ctrl: RTL and testbench

FLAPPY_GAME_CTRL -- requirements
Module: flappy_game_ctrl

---
 rtl/flappy_game_ctrl.sv | 176 +++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flappy_game_ctrl
// Brief    : Flappy-bird game state machine: bird physics, pipe scroll, BCD score.
// Revision : 1.0
// ============================================================================
module flappy_game_ctrl #(
    parameter int Y_START      = 240,
    parameter int Y_MAX        = 464,
    parameter int FLAP_VEL     = -8,
    parameter int GRAVITY      = 1,
    parameter int VEL_MAX      = 8,
    parameter int PIPE_X_START = 640,
    parameter int PIPE_SPEED   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              flap,
    input  logic              collide,
    output logic [1:0]        state,
    output logic [9:0]        bird_y,
    output logic signed [5:0] bird_vel,
    output logic [9:0]        pipe_x,
    output logic [2:0]        gap_sel,
    output logic [15:0]       score
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [9:0]        c_y_start    = 10'(Y_START);
    localparam logic [9:0]        c_y_max      = 10'(Y_MAX);
    localparam logic signed [5:0] c_flap_vel   = 6'(FLAP_VEL);
    localparam logic signed [6:0] c_gravity    = 7'(GRAVITY);
    localparam logic signed [6:0] c_vel_max    = 7'(VEL_MAX);
    localparam logic [9:0]        c_pipe_start = 10'(PIPE_X_START);
    localparam logic [9:0]        c_pipe_speed = 10'(PIPE_SPEED);
    localparam logic [7:0]        c_lfsr_seed  = 8'hA5;

    state_t             r_state;
    logic [9:0]         r_bird_y;
    logic signed [5:0]  r_bird_vel;
    logic [9:0]         r_pipe_x;
    logic [2:0]         r_gap_sel;
    logic [15:0]        r_score;
    logic               r_pending;
    logic [7:0]         r_lfsr;

    logic signed [11:0] w_sum;
    logic signed [6:0]  w_vel_inc;
    logic signed [5:0]  w_vel_grav;
    logic signed [5:0]  w_vel_play;
    logic [9:0]         w_y_next;
    logic               w_pending;
    logic               w_below;
    logic               w_floor;
    logic               w_reload;
    logic               w_fb;

    // Four-digit BCD increment that sticks at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        w_pending  = r_pending | flap;
        w_sum      = $signed({2'b00, r_bird_y}) + $signed({{6{r_bird_vel[5]}}, r_bird_vel});
        w_below    = w_sum[11];
        w_floor    = !w_sum[11] && (w_sum[10:0] >= {1'b0, c_y_max});
        w_vel_inc  = $signed({r_bird_vel[5], r_bird_vel}) + c_gravity;
        w_vel_grav = (w_vel_inc > c_vel_max) ? c_vel_max[5:0] : w_vel_inc[5:0];
        // A pending flap wins over the ceiling stop.
        w_vel_play = w_pending ? c_flap_vel : (w_below ? 6'sd0 : w_vel_grav);
        w_y_next   = w_below ? 10'd0 : (w_floor ? c_y_max : w_sum[9:0]);
        w_reload   = (r_pipe_x <= c_pipe_speed);
        w_fb       = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bird_y   <= c_y_start;
            r_bird_vel <= 6'sd0;
            r_pipe_x   <= c_pipe_start;
            r_gap_sel  <= 3'd0;
            r_score    <= 16'h0000;
            r_pending  <= 1'b0;
            r_lfsr     <= c_lfsr_seed;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
            case (r_state)
                S_IDLE: begin
                    r_bird_y   <= c_y_start;
                    r_bird_vel <= 6'sd0;
                    r_pipe_x   <= c_pipe_start;
                    r_pending  <= 1'b0;
                    if (flap) begin
                        r_state    <= S_PLAY;
                        r_bird_vel <= c_flap_vel;
                        r_score    <= 16'h0000;
                    end
                end
                S_PLAY: begin
                    // A collision pre-empts everything else in the same cycle.
                    if (collide) begin
                        r_state   <= S_DYING;
                        r_pending <= 1'b0;
                    end else if (frame_tick) begin
                        r_pending  <= 1'b0;
                        r_bird_y   <= w_y_next;
                        r_bird_vel <= w_vel_play;
                        if (w_floor) begin
                            r_state <= S_OVER;
                        end
                        if (w_reload) begin
                            r_pipe_x  <= c_pipe_start;
                            r_gap_sel <= r_lfsr[2:0];
                            r_score   <= bcd_inc(r_score);
                        end else begin
                            r_pipe_x <= r_pipe_x - c_pipe_speed;
                        end
                    end else if (flap) begin
                        r_pending <= 1'b1;
                    end
                end
                S_DYING: begin
                    if (frame_tick) begin
                        r_bird_y   <= w_y_next;
                        r_bird_vel <= w_vel_grav;
                        if (w_floor) begin
                            r_state <= S_OVER;
                        end
                    end
                end
                S_OVER: begin
                    if (flap) begin
                        r_state    <= S_IDLE;
                        r_bird_y   <= c_y_start;
                        r_bird_vel <= 6'sd0;
                        r_pipe_x   <= c_pipe_start;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign state    = r_state;
    assign bird_y   = r_bird_y;
    assign bird_vel = r_bird_vel;
    assign pipe_x   = r_pipe_x;
    assign gap_sel  = r_gap_sel;
    assign score    = r_score;
endmodule
`default_nettype wire

// File: tb/tb_flappy_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_flappy_game_ctrl
// Brief    : Directed vector bench for flappy_game_ctrl (default and short-pipe builds).
// Revision : 1.0
// ============================================================================
module tb_flappy_game_ctrl;
    logic clk = 1'b0;
    logic rst, frame_tick, flap, collide;

    logic [1:0]        state1, state2;
    logic [9:0]        bird_y1, bird_y2, pipe_x1, pipe_x2;
    logic signed [5:0] bird_vel1, bird_vel2;
    logic [2:0]        gap_sel1, gap_sel2;
    logic [15:0]       score1, score2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_lfsr;
    logic [7:0] last_lfsr;
    int         sc_tab[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 16};

    typedef struct {
        logic r, ft, fl, co;
        int   st, y, vel, px, sc;
    } vec_t;
    vec_t vecs[17];

    always #5 clk = ~clk;

    flappy_game_ctrl dut1 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .flap(flap), .collide(collide),
        .state(state1), .bird_y(bird_y1), .bird_vel(bird_vel1), .pipe_x(pipe_x1),
        .gap_sel(gap_sel1), .score(score1)
    );

    flappy_game_ctrl #(.PIPE_X_START(4), .PIPE_SPEED(2)) dut2 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .flap(flap), .collide(collide),
        .state(state2), .bird_y(bird_y2), .bird_vel(bird_vel2), .pipe_x(pipe_x2),
        .gap_sel(gap_sel2), .score(score2)
    );

    // Reference 8-bit LFSR, taps 8,6,5,4, free-running from reset.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic vec_t mk(input int r, input int ft, input int fl, input int co,
                                input int st, input int y, input int vel, input int px, input int sc);
        vec_t v;
        v.r = (r != 0); v.ft = (ft != 0); v.fl = (fl != 0); v.co = (co != 0);
        v.st = st; v.y = y; v.vel = vel; v.px = px; v.sc = sc;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic check_dut(input int which, input string tag, input int st, input int y,
                             input int vel, input int px, input int sc);
        if (which == 1) begin
            chk({tag, "_state"}, int'(state1), st);
            chk({tag, "_y"}, int'(bird_y1), y);
            chk({tag, "_vel"}, int'(bird_vel1), vel);
            chk({tag, "_pipe"}, int'(pipe_x1), px);
            chk({tag, "_score"}, int'(score1), sc);
        end else begin
            chk({tag, "_state"}, int'(state2), st);
            chk({tag, "_y"}, int'(bird_y2), y);
            chk({tag, "_vel"}, int'(bird_vel2), vel);
            chk({tag, "_pipe"}, int'(pipe_x2), px);
            chk({tag, "_score"}, int'(score2), sc);
        end
    endtask

    task automatic step(input logic r, input logic ft, input logic fl, input logic co);
        @(negedge clk);
        last_lfsr  = m_lfsr;
        rst        = r;
        frame_tick = ft;
        flap       = fl;
        collide    = co;
        @(posedge clk);
        #1;
        rst = 1'b0; frame_tick = 1'b0; flap = 1'b0; collide = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap_exp;
        int tries;
        rst = 1'b1; frame_tick = 1'b0; flap = 1'b0; collide = 1'b0;
        repeat (2) @(posedge clk);

        //           r ft fl co  st   y  vel   px  sc
        vecs[0]  = mk(1, 0, 0, 0, 0, 240,  0, 640, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 240,  0, 640, 0);
        vecs[2]  = mk(0, 0, 0, 1, 0, 240,  0, 640, 0);
        vecs[3]  = mk(0, 0, 1, 0, 1, 240, -8, 640, 0);
        vecs[4]  = mk(0, 0, 0, 0, 1, 240, -8, 640, 0);
        vecs[5]  = mk(0, 1, 0, 0, 1, 232, -7, 638, 0);
        vecs[6]  = mk(0, 1, 0, 0, 1, 225, -6, 636, 0);
        vecs[7]  = mk(0, 1, 0, 0, 1, 219, -5, 634, 0);
        vecs[8]  = mk(0, 0, 1, 0, 1, 219, -5, 634, 0);
        vecs[9]  = mk(0, 0, 0, 0, 1, 219, -5, 634, 0);
        vecs[10] = mk(0, 1, 0, 0, 1, 214, -8, 632, 0);
        vecs[11] = mk(0, 1, 0, 0, 1, 206, -7, 630, 0);
        vecs[12] = mk(0, 0, 0, 1, 2, 206, -7, 630, 0);
        vecs[13] = mk(0, 0, 1, 0, 2, 206, -7, 630, 0);
        vecs[14] = mk(0, 1, 0, 0, 2, 199, -6, 630, 0);
        vecs[15] = mk(0, 1, 0, 1, 2, 193, -5, 630, 0);
        vecs[16] = mk(1, 0, 0, 0, 0, 240,  0, 640, 0);

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].r, vecs[i].ft, vecs[i].fl, vecs[i].co);
            check_dut(1, $sformatf("vec%0d", i), vecs[i].st, vecs[i].y, vecs[i].vel,
                      vecs[i].px, vecs[i].sc);
        end
        chk("reset_gap", int'(gap_sel1), 0);

        // Flap coincident with a tick at bird_y=300, bird_vel=+3.
        step(0, 0, 1, 0);
        repeat (32) step(0, 1, 0, 0);
        check_dut(1, "fall_cap", 1, 360, 8, 576, 0);
        step(0, 1, 1, 0);
        repeat (6) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        check_dut(1, "reflap", 1, 333, -8, 560, 0);
        repeat (11) step(0, 1, 0, 0);
        check_dut(1, "pre_tickflap", 1, 300, 3, 538, 0);
        step(0, 1, 1, 0);
        check_dut(1, "tickflap", 1, 303, -8, 536, 0);

        // Ceiling clamp, with and without a pending flap.
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (30) step(0, 1, 1, 0);
        check_dut(1, "ceil_reach", 1, 0, -8, 580, 0);
        step(0, 1, 1, 0);
        check_dut(1, "ceil_flap", 1, 0, -8, 578, 0);
        step(0, 1, 0, 0);
        check_dut(1, "ceil_stop", 1, 0, 0, 576, 0);
        step(0, 1, 0, 0);
        check_dut(1, "ceil_fall", 1, 0, 1, 574, 0);

        // Short-pipe build: reloads, gap selection and BCD carry.
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        check_dut(2, "sp_start", 1, 240, -8, 4, 0);
        gap_exp = int'(gap_sel2);
        for (int t = 1; t <= 20; t++) begin
            step(0, 1, (t % 4 == 0), 0);
            chk($sformatf("sp_pipe_t%0d", t), int'(pipe_x2), (t % 2 == 1) ? 2 : 4);
            if (t % 2 == 0) begin
                gap_exp = int'(last_lfsr[2:0]);
                chk($sformatf("sp_score_t%0d", t), int'(score2), sc_tab[t/2 - 1]);
            end
            chk($sformatf("sp_gap_t%0d", t), int'(gap_sel2), gap_exp);
        end
        check_dut(2, "sp_end", 1, 110, -8, 4, 16'h0010);

        // Collision on a reloading tick freezes pipe and score.
        step(0, 1, 0, 0);
        check_dut(2, "pre_col", 1, 102, -7, 2, 16'h0010);
        step(0, 1, 0, 1);
        check_dut(2, "col_reload", 2, 102, -7, 2, 16'h0010);
        chk("col_gap", int'(gap_sel2), gap_exp);
        step(0, 1, 0, 0);
        check_dut(2, "dying1", 2, 95, -6, 2, 16'h0010);

        tries = 0;
        while (state2 != 2'd3 && tries < 200) begin
            step(0, 1, 0, 0);
            tries++;
        end
        chk("dying_to_over_state", int'(state2), 3);
        chk("dying_to_over_y", int'(bird_y2), 464);
        chk("dying_to_over_score", int'(score2), 16'h0010);
        chk("dying_to_over_pipe", int'(pipe_x2), 2);
        step(0, 1, 0, 0);
        chk("over_hold_state", int'(state2), 3);
        chk("over_hold_y", int'(bird_y2), 464);
        step(0, 0, 1, 0);
        check_dut(2, "over_to_idle", 0, 240, 0, 4, 16'h0010);
        step(0, 0, 1, 0);
        check_dut(2, "replay", 1, 240, -8, 4, 0);

        // Long run at the ceiling: hundreds carry and saturation.
        repeat (300) step(0, 1, 1, 0);
        chk("score_150", int'(score2), 16'h0150);
        chk("score_150_state", int'(state2), 1);
        repeat (19698) step(0, 1, 1, 0);
        chk("score_9999", int'(score2), 16'h9999);
        repeat (4) step(0, 1, 1, 0);
        chk("score_sat", int'(score2), 16'h9999);
        chk("score_sat_state", int'(state2), 1);

        // Asynchronous reset mid-PLAY, then first flap honoured.
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check_dut(1, "pre_arst", 1, 225, -6, 636, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_dut(1, "arst", 0, 240, 0, 640, 0);
        chk("arst_gap", int'(gap_sel1), 0);
        #2;
        rst = 1'b0;
        step(0, 0, 1, 0);
        check_dut(1, "first_flap", 1, 240, -8, 640, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
